nes_host_ctrl: RTL and testbench

//  Host-side command stage upstream of the nes top level. Accepts 16-bit host

---
 rtl/nes_host_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_nes_host_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_host_ctrl.sv
// nes_host_ctrl
//   Host-side command stage in front of the NES core. Host writes carry an
//   8-bit opcode and an 8-bit data byte plus a 16-bit address; they are
//   buffered in a FIFO and sequenced into CPU control (cpu_reset / cpu_ready)
//   and program-memory load strobes, so back-to-back host writes are never
//   dropped.
//
// Ports
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   chipselect, write     host write, accepted when chipselect & write & !waitrequest
//   chipselect, read      host read, readdata valid on the following cycle
//   writedata[15:0]       [15:8] opcode, [7:0] data byte
//   address[15:0]         load address for WRITE_MEM; read select (16'hFFFF = status)
//   waitrequest           high while the command FIFO is full
//   readdata[7:0]         registered read data
//   cpu_dout[7:0]         CPU data-out byte returned on non-status reads
//   cpu_reset, cpu_ready  CPU reset (active high) and run enable
//   ld_write, ld_addr,    one-cycle program-memory write strobe with its
//   ld_data               address and data
//
// Handshake: a host write is taken on the rising edge where chipselect, write
// are high and waitrequest is low; while waitrequest is high the host holds
// writedata/address stable. Reads never stall and have no side effects.
//
// Opcodes: 0 RESET_CPU, 1 START_CPU, 2 PAUSE_CPU, 3 WRITE_MEM, others ignored.

module nes_host_ctrl #(
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] writedata,
  input  logic [15:0] address,
  output logic        waitrequest,
  output logic [7:0]  readdata,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_reset,
  output logic        cpu_ready,
  output logic        ld_write,
  output logic [15:0] ld_addr,
  output logic [7:0]  ld_data
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  localparam logic [7:0] OP_RESET_CPU = 8'h00;
  localparam logic [7:0] OP_START_CPU = 8'h01;
  localparam logic [7:0] OP_PAUSE_CPU = 8'h02;
  localparam logic [7:0] OP_WRITE_MEM = 8'h03;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO: entry = {op[7:0], data[7:0], addr[15:0]}
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [31:0] head;
  logic [7:0]  head_op;
  logic [7:0]  head_data;
  logic [15:0] head_addr;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign waitrequest = fifo_full;
  // A full FIFO refuses the push even if the FSM pops on the same edge; the
  // host sees waitrequest for that whole cycle anyway.
  assign push        = chipselect & write & ~fifo_full;

  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[31:24];
  assign head_data = head[23:16];
  assign head_addr = head[15:0];

  // Storage has no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {writedata, address};
    end
  end

  // Pointers are exactly AW bits wide, so they wrap mod FIFO_DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           ld_fire;

  logic        cpu_reset_q, cpu_reset_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        ld_write_q, ld_write_d;
  logic [15:0] ld_addr_q, ld_addr_d;
  logic [7:0]  ld_data_q, ld_data_d;
  logic [7:0]  readdata_q, readdata_d;
  logic [5:0]  count6;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HALT;
      rst_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cpu_reset_q <= 1'b0;
      cpu_ready_q <= 1'b0;
      ld_write_q  <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_ready_q <= cpu_ready_d;
      ld_write_q  <= ld_write_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      readdata_q  <= readdata_d;
    end
  end

  // Next-state logic; also the only source of FIFO pops (at most one per cycle).
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    pop       = 1'b0;
    ld_fire   = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_op)
            OP_RESET_CPU: begin
              rst_cnt_d = RCW'(RESET_CYCLES);
              state_d   = ST_RST;
            end
            OP_START_CPU: state_d = ST_RUN;
            OP_PAUSE_CPU: state_d = ST_HALT;
            OP_WRITE_MEM: ld_fire = 1'b1;
            default:      state_d = ST_HALT;
          endcase
        end
      end
      ST_RST: begin
        // Counter is loaded with RESET_CYCLES on entry and leaves at 1, so
        // the state (and cpu_reset) lasts exactly RESET_CYCLES cycles.
        rst_cnt_d = rst_cnt_q - RCW'(1);
        if (rst_cnt_q <= RCW'(1)) begin
          rst_cnt_d = '0;
          state_d   = ST_HALT;
        end
      end
      ST_RUN: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_RESET_CPU: begin
              pop       = 1'b1;
              rst_cnt_d = RCW'(RESET_CYCLES);
              state_d   = ST_RST;
            end
            OP_PAUSE_CPU: begin
              pop     = 1'b1;
              state_d = ST_HALT;
            end
            // Memory loads only happen with the CPU halted: leave the entry at
            // the head and let HALT execute it. The CPU is not restarted
            // afterwards; that takes an explicit START_CPU.
            OP_WRITE_MEM: state_d = ST_HALT;
            default:      pop = 1'b1;
          endcase
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Output logic, decoded from the next state so the registered outputs
  // change on the cycle right after the pop.
  always_comb begin
    cpu_reset_d = (state_d == ST_RST);
    cpu_ready_d = (state_d == ST_RUN);
    ld_write_d  = ld_fire;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;
    if (ld_fire) begin
      ld_addr_d = head_addr;
      ld_data_d = head_data;
    end
  end

  // Read path: status word at 16'hFFFF, CPU data byte anywhere else.
  assign count6 = 6'(count_q);

  always_comb begin
    readdata_d = readdata_q;
    if (chipselect && read) begin
      if (address == 16'hFFFF) begin
        readdata_d = {cpu_reset_q, cpu_ready_q, count6};
      end else begin
        readdata_d = cpu_dout;
      end
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign cpu_ready = cpu_ready_q;
  assign ld_write  = ld_write_q;
  assign ld_addr   = ld_addr_q;
  assign ld_data   = ld_data_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_nes_host_ctrl.sv
module tb_nes_host_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, write, read;
  logic [15:0] writedata, address;
  logic        waitrequest;
  logic [7:0]  readdata;
  logic [7:0]  cpu_dout;
  logic        cpu_reset, cpu_ready, ld_write;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  always #5 clk = ~clk;

  nes_host_ctrl #(.FIFO_DEPTH(8), .RESET_CYCLES(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .address    (address),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .cpu_dout   (cpu_dout),
    .cpu_reset  (cpu_reset),
    .cpu_ready  (cpu_ready),
    .ld_write   (ld_write),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [23:0] exp_q[$];     // expected {ld_addr, ld_data}
  logic [7:0]  rd_exp_q[$];  // expected readdata
  int          ld_cyc_q[$];
  int          ld_seen   = 0;
  int          ready_cyc = 0;
  int          rdy_last  = 0;
  logic        rd_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_v <= chipselect && read;
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or read data.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ld_write) begin
        ld_seen++;
        ld_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ld_unexpected: got %0h/%0h expected no strobe", ld_addr, ld_data);
        end else begin
          chk("ld_write", 32'({ld_addr, ld_data}), 32'(exp_q.pop_front()));
        end
      end
      if (cpu_ready) begin
        ready_cyc++;
        rdy_last = cyc;
      end
      if (rd_v) begin
        if (rd_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %0h expected none", readdata);
        end else begin
          chk("readdata", 32'(readdata), 32'(rd_exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic host_write(input logic [15:0] wd, input logic [15:0] ad,
                            input bit exp_ld, output int waited);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    writedata  = wd;
    address    = ad;
    waited     = 0;
    @(negedge clk);
    while (waitrequest && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waitrequest) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got waitrequest=1 expected 0 within 200 cycles");
    end
    if (exp_ld && wd[15:8] == 8'h03) exp_q.push_back({ad, wd[7:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] ad, input logic [7:0] exp);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = ad;
    rd_exp_q.push_back(exp);
    @(posedge clk);
    #1;
    read       = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int w, n, hi, rdy_bad, base;
    int waits[9];
    reset_n = 1'b0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    writedata = '0; address = '0; cpu_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'h0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rst_ld_write",  32'(ld_write), 32'h0);
    chk("rst_ld_addr",   32'(ld_addr), 32'h0);
    chk("rst_ld_data",   32'(ld_data), 32'h0);
    chk("rst_readdata",  32'(readdata), 32'h0);
    chk("rst_waitreq",   32'(waitrequest), 32'h0);
    @(posedge clk); #1;
    host_read(16'hFFFF, 8'h00);

    // 1: RESET_CPU holds cpu_reset exactly 8 cycles
    host_write(16'h0000, 16'h0000, 1'b0, w);
    host_idle();
    n = 0;
    while (!cpu_reset && n < 20) begin @(negedge clk); n++; end
    hi = 0; rdy_bad = 0;
    while (cpu_reset && hi < 50) begin
      if (cpu_ready) rdy_bad++;
      hi++;
      @(negedge clk);
    end
    chk("t1_reset_len", 32'(hi), 32'd8);
    chk("t1_ready_in_rst", 32'(rdy_bad), 32'd0);
    chk("t1_halt_reset", 32'(cpu_reset), 32'h0);
    chk("t1_halt_ready", 32'(cpu_ready), 32'h0);
    @(posedge clk); #1;

    // 2: three WRITE_MEMs give three consecutive strobes
    ld_cyc_q.delete();
    host_write(16'h03AA, 16'h0300, 1'b1, w);
    host_write(16'h03BB, 16'h0301, 1'b1, w);
    host_write(16'h03CC, 16'h0302, 1'b1, w);
    host_idle();
    wait_cycles(8);
    chk("t2_strobes", 32'(ld_cyc_q.size()), 32'd3);
    if (ld_cyc_q.size() == 3) begin
      chk("t2_gap01", 32'(ld_cyc_q[1] - ld_cyc_q[0]), 32'd1);
      chk("t2_gap12", 32'(ld_cyc_q[2] - ld_cyc_q[1]), 32'd1);
    end

    // 3: START then WRITE_MEM: one ready cycle, then the load from HALT
    ld_cyc_q.delete();
    ready_cyc = 0;
    host_write(16'h0100, 16'h0000, 1'b1, w);
    host_write(16'h0355, 16'h8000, 1'b1, w);
    host_idle();
    wait_cycles(12);
    chk("t3_ready_cycles", 32'(ready_cyc), 32'd1);
    chk("t3_strobes", 32'(ld_cyc_q.size()), 32'd1);
    if (ld_cyc_q.size() == 1) chk("t3_ld_after_ready", 32'(ld_cyc_q[0] - rdy_last), 32'd2);
    host_write(16'h0100, 16'h0000, 1'b1, w);
    host_idle();
    wait_cycles(3);
    chk("t3_restart_ready", 32'(cpu_ready), 32'h1);
    host_write(16'h0200, 16'h0000, 1'b1, w);
    host_idle();
    wait_cycles(3);
    chk("t3_pause_ready", 32'(cpu_ready), 32'h0);

    // 4: fill the FIFO while in RST; 9th write stalls until the first pop
    host_write(16'h0000, 16'h0000, 1'b0, w);
    for (int i = 0; i < 9; i++) begin
      host_write({8'h03, 8'(8'h40 + i)}, 16'(16'h2000 + i), 1'b1, waits[i]);
    end
    host_idle();
    n = 0;
    for (int i = 0; i < 8; i++) n += waits[i];
    chk("t4_no_wait_first8", 32'(n), 32'd0);
    chk("t4_ninth_waited", 32'(waits[8] > 0), 32'h1);
    wait_cycles(20);
    chk("t4_all_drained", 32'(exp_q.size()), 32'd0);
    host_read(16'hFFFF, 8'h00);

    // 5: status read with 3 entries queued (held in RST), then a data read
    host_write(16'h0000, 16'h0000, 1'b0, w);
    host_write(16'h0311, 16'h0400, 1'b1, w);
    host_write(16'h0322, 16'h0401, 1'b1, w);
    host_write(16'h0333, 16'h0402, 1'b1, w);
    host_read(16'hFFFF, 8'h83);
    host_read(16'hFFFF, 8'h83);
    cpu_dout = 8'h5A;
    host_read(16'h0000, 8'h5A);
    cpu_dout = 8'h00;
    wait_cycles(20);

    // 6: async reset in the middle of a WRITE_MEM burst
    base = ld_seen;
    host_write(16'h0000, 16'h0000, 1'b0, w);
    host_write(16'h0301, 16'h1000, 1'b1, w);
    host_write(16'h0302, 16'h1001, 1'b1, w);
    host_write(16'h0303, 16'h1002, 1'b0, w);
    host_write(16'h0304, 16'h1003, 1'b0, w);
    host_idle();
    n = 0;
    while (ld_seen < base + 2 && n < 60) begin @(negedge clk); #1; n++; end
    chk("t6_two_strobes", 32'(ld_seen - base), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_ld_write", 32'(ld_write), 32'h0);
    chk("t6_ld_addr",  32'(ld_addr), 32'h0);
    chk("t6_ld_data",  32'(ld_data), 32'h0);
    chk("t6_waitreq",  32'(waitrequest), 32'h0);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'h0);
    chk("t6_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("t6_readdata", 32'(readdata), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(15);
    chk("t6_no_more_strobes", 32'(ld_seen - base), 32'd2);
    host_read(16'hFFFF, 8'h00);
    wait_cycles(2);

    chk("end_ld_queue", 32'(exp_q.size()), 32'd0);
    chk("end_rd_queue", 32'(rd_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
